controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
Moore control FSM that sequences the shared multicycle MIPS datapath (single memory, single ALU, IR, PC, register file). It decodes the opcode held in IR and drives every datapath mux select and write enable, one micro-step per clock. It stalls on instruction and data memory fetches through a ready handshake. It counts retired instructions and flags illegal opcodes. It replaces the single-cycle control in the processador top level.

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word
OP_SW, 6'h2B, store word
OP_BEQ, 6'h04, branch if equal
OP_BNE, 6'h05, branch if not equal
OP_ADDI, 6'h08, add immediate
OP_J, 6'h02, jump

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous reset, active-high
opcode  input  6  instr[31:26] from IR; stable outside FETCH
zero  input  1  ALU Zero flag
mem_ready  input  1  memory read data valid this cycle
pc_en  output  1  PC register load enable
ir_write  output  1  IR load enable
iord  output  1  memory address mux: 0=PC, 1=ALUOut
mem_write  output  1  memory write strobe
reg_dst  output  1  write register: 0=rt, 1=rd
mem_to_reg  output  1  write data: 0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  output  2  00=add, 01=sub, 10=use funct
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse on an unknown opcode
state  output  4  current state (debug)
instr_count  output  32  retired instruction count

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH on the next edge.
- Reset: at a rising edge with reset=1, state<=FETCH, instr_count<=0, illegal_op<=0, regardless of the current state (this aborts any instruction in flight). While reset=1, pc_en, ir_write, mem_write and reg_write are forced to 0 combinationally.
- Default outputs: all outputs not listed for a state are 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - If mem_ready=1: ir_write=1, pc_en=1, next state DECODE.
  - Otherwise: hold in FETCH with no writes.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - LW/SW -> MEMADR; RTYPE -> EXECUTE; BEQ/BNE -> BRANCH; ADDI -> ADDIEXEC; J -> JUMP.
  - Any other opcode -> FETCH, with illegal_op registered high for exactly the next cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW -> MEMREAD, SW -> MEMWRITE.
- MEMREAD: iord=1. Next MEMWB when mem_ready=1, else hold.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
- MEMWRITE: iord=1, mem_write=1 for exactly one cycle. Next FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_en=zero for BEQ and pc_en=~zero for BNE (combinational on zero). Next FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
- JUMP: pc_src=10, pc_en=1. Next FETCH.
- instr_count increments by 1 on each transition to FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB or JUMP. It wraps from 32'hFFFFFFFF to 0. Illegal-opcode returns to FETCH do not increment it.
- Latency with mem_ready held at 1: R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3 cycles. Each mem_ready=0 cycle in FETCH or MEMREAD adds one cycle.

Test Plan:
- Reset held for 2 cycles, then released with mem_ready=1 and opcode=6'h00 -> state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_count=1.
- lw (6'h23), with mem_ready=0 for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0 (3 held for 4 cycles); iord=1 throughout state 3; mem_to_reg=1 and reg_write=1 in state 4.
- beq (6'h04) with zero=1, then with zero=0 -> pc_en=1 in BRANCH for the first, 0 for the second. bne (6'h05) with zero=0 -> pc_en=1. Each is 3 cycles.
- Opcode 6'h3F -> states 0,1,0; illegal_op=1 for exactly one cycle; instr_count unchanged; no reg_write or mem_write at any point.
- sw (6'h2B) with reset asserted in the MEMADR cycle -> state=0 after the edge; mem_write never asserted; instr_count=0.
- Force instr_count to 32'hFFFFFFFF, then complete a j (6'h02) -> pc_src=10 and pc_en=1 in JUMP; instr_count wraps to 0.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: sequences the shared datapath one micro-step
// per clock, stalls on memory ready, counts retired instructions.
module controle_multiciclo (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  logic [3:0] nxt;
  logic       pc_en_c;
  logic       ir_write_c;
  logic       mem_write_c;
  logic       reg_write_c;
  logic       bad_op;
  logic       retire;

  always_comb begin
    nxt         = FETCH;
    pc_en_c     = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    bad_op      = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          nxt        = DECODE;
        end else begin
          nxt = FETCH;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   nxt = MEMADR;
          OP_RTYPE:       nxt = EXECUTE;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_ADDI:        nxt = ADDIEXEC;
          OP_J:           nxt = JUMP;
          default:        bad_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        iord = 1'b1;
        nxt  = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
        retire      = 1'b1;
      end
      MEMWRITE: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
        retire      = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = ALUWB;
      end
      ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        retire      = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en_c   = (opcode == OP_BNE) ? ~zero : zero;
        retire    = 1'b1;
      end
      ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
      end
      JUMP: begin
        pc_src  = 2'b10;
        pc_en_c = 1'b1;
        retire  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // write strobes are suppressed while reset is held
  assign pc_en     = pc_en_c & ~reset;
  assign ir_write  = ir_write_c & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign reg_write = reg_write_c & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      instr_count <= 32'd0;
      illegal_op  <= 1'b0;
    end else begin
      state      <= nxt;
      illegal_op <= bad_op;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: state walks, stalls, branches,
// illegal opcodes, reset abort and counter wrap.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, ir_write, iord, mem_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
    .iord(iord), .mem_write(mem_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .state(state),
    .instr_count(instr_count)
  );

  task automatic test_reset();
    logic [3:0] exp [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_bad++; $display("FAIL rst_state got %0d want 0", state);
    end
    n_cmp++;
    if (instr_count !== 32'd0) begin
      n_bad++; $display("FAIL rst_count got %0d want 0", instr_count);
    end
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_bad++; $display("FAIL rst_illegal got %b want 0", illegal_op);
    end
    n_cmp++;
    if ({pc_en, ir_write} !== 2'b00) begin
      n_bad++; $display("FAIL rst_gate got %b want 00", {pc_en, ir_write});
    end
    reset = 1'b0; #1;
    n_cmp++;
    if ({pc_en, ir_write} !== 2'b11) begin
      n_bad++; $display("FAIL fetch_we got %b want 11", {pc_en, ir_write});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (state !== exp[i]) begin
        n_bad++; $display("FAIL rtype_st%0d got %0d want %0d", i, state, exp[i]);
      end
      n_cmp++;
      if ({reg_write, reg_dst} !== {2{exp[i] == 4'd7}}) begin
        n_bad++;
        $display("FAIL rtype_wr%0d got %b want %b", i,
                 {reg_write, reg_dst}, {2{exp[i] == 4'd7}});
      end
    end
    n_cmp++;
    if (instr_count !== 32'd1) begin
      n_bad++; $display("FAIL rtype_count got %0d want 1", instr_count);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] exp [8] = '{1, 2, 3, 3, 3, 3, 4, 0};
    logic       mr  [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    opcode = 6'h23; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ready = mr[i];
      #1;
      n_cmp++;
      if (state !== exp[i]) begin
        n_bad++; $display("FAIL lw_st%0d got %0d want %0d", i, state, exp[i]);
      end
      if (exp[i] == 4'd3) begin
        n_cmp++;
        if (iord !== 1'b1) begin
          n_bad++; $display("FAIL lw_iord%0d got %b want 1", i, iord);
        end
      end
      if (exp[i] == 4'd4) begin
        n_cmp++;
        if ({mem_to_reg, reg_write} !== 2'b11) begin
          n_bad++;
          $display("FAIL lw_wb got %b want 11", {mem_to_reg, reg_write});
        end
      end
    end
    n_cmp++;
    if (instr_count !== 32'd2) begin
      n_bad++; $display("FAIL lw_count got %0d want 2", instr_count);
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z,
                             input logic want);
    opcode = op; zero = z; mem_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (state !== 4'd1) begin
      n_bad++; $display("FAIL br%0h_dec got %0d want 1", op, state);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({state, pc_en, pc_src, alu_op} !== {4'd8, want, 2'b01, 2'b01}) begin
      n_bad++;
      $display("FAIL br%0h_z%0b st/pc_en/src/op got %0d/%b/%b/%b want 8/%b/01/01",
               op, z, state, pc_en, pc_src, alu_op, want);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_bad++; $display("FAIL br%0h_end got %0d want 0", op, state);
    end
  endtask

  task automatic test_illegal(input logic [31:0] cnt);
    opcode = 6'h3F; mem_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({state, illegal_op} !== {4'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL ill_dec st/ill got %0d/%b want 1/0", state, illegal_op);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if ({state, illegal_op} !== {4'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL ill_pulse st/ill got %0d/%b want 0/1", state, illegal_op);
    end
    n_cmp++;
    if (instr_count !== cnt) begin
      n_bad++; $display("FAIL ill_count got %0d want %0d", instr_count, cnt);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({state, illegal_op} !== {4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL ill_once st/ill got %0d/%b want 0/0", state, illegal_op);
    end
  endtask

  task automatic test_addi_sw();
    logic [3:0] ea [4] = '{1, 9, 10, 0};
    logic [3:0] es [4] = '{1, 2, 5, 0};
    opcode = 6'h08; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({state, reg_write, reg_dst} !== {ea[i], ea[i] == 4'd10, 1'b0}) begin
        n_bad++;
        $display("FAIL addi_st%0d st/rw/rd got %0d/%b/%b want %0d/%b/0",
                 i, state, reg_write, reg_dst, ea[i], ea[i] == 4'd10);
      end
    end
    opcode = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({state, mem_write} !== {es[i], es[i] == 4'd5}) begin
        n_bad++;
        $display("FAIL sw_st%0d st/mw got %0d/%b want %0d/%b",
                 i, state, mem_write, es[i], es[i] == 4'd5);
      end
    end
    n_cmp++;
    if (instr_count !== 32'd8) begin
      n_bad++; $display("FAIL addi_sw_count got %0d want 8", instr_count);
    end
  endtask

  task automatic test_sw_reset();
    logic mw_seen = 1'b0;
    opcode = 6'h2B; mem_ready = 1'b1;
    @(negedge clk); #1;
    mw_seen |= mem_write;
    @(negedge clk);
    reset = 1'b1;
    #1;
    mw_seen |= mem_write;
    n_cmp++;
    if (state !== 4'd2) begin
      n_bad++; $display("FAIL swr_memadr got %0d want 2", state);
    end
    @(negedge clk); #1;
    mw_seen |= mem_write;
    n_cmp++;
    if ({state, instr_count} !== {4'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL swr_abort st/cnt got %0d/%0d want 0/0", state, instr_count);
    end
    n_cmp++;
    if (mw_seen !== 1'b0) begin
      n_bad++; $display("FAIL swr_memwrite got %b want 0", mw_seen);
    end
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count;
    opcode = 6'h02; mem_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({state, instr_count} !== {4'd1, 32'hFFFF_FFFF}) begin
      n_bad++;
      $display("FAIL wrap_pre st/cnt got %0d/%h want 1/ffffffff",
               state, instr_count);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({state, pc_src, pc_en} !== {4'd11, 2'b10, 1'b1}) begin
      n_bad++;
      $display("FAIL jump st/src/en got %0d/%b/%b want 11/10/1",
               state, pc_src, pc_en);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({state, instr_count} !== {4'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL wrap st/cnt got %0d/%h want 0/0", state, instr_count);
    end
  endtask

  always @(negedge clk) begin
    if (state == 4'd1 && opcode == 6'h3F && (reg_write || mem_write)) begin
      n_bad++; $display("FAIL ill_writes rw/mw %b/%b want 0/0",
                        reg_write, mem_write);
    end
  end

  initial begin
    test_reset();
    test_lw_stall();
    test_branch(6'h04, 1'b1, 1'b1);
    test_branch(6'h04, 1'b0, 1'b0);
    test_branch(6'h05, 1'b0, 1'b1);
    test_branch(6'h05, 1'b1, 1'b0);
    test_illegal(32'd6);
    test_addi_sw();
    test_sw_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
